// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle for regfile_wr_arbiter: writeback and mult/div producers,
// decode hazard lookups, and the registered register-bank write port.
interface regfile_wr_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_addr;
    logic [DATA_W-1:0] md_data;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              haz_a;
    logic              haz_b;
    logic              stall_req;
    logic [CNT_W-1:0]  fifo_count;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Producer / decode side
    modport master (
        output wb_valid, wb_addr, wb_data,
        output md_valid, md_addr, md_data,
        output rs_addr, rt_addr,
        input  md_ready, haz_a, haz_b, stall_req, fifo_count,
        input  rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  md_valid, md_addr, md_data,
        input  rs_addr, rt_addr,
        output md_ready, haz_a, haz_b, stall_req, fifo_count,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-bank write-port arbiter. Pipeline writeback always wins the port;
// mult/div results wait in a small FIFO and drain on idle slots. Writes to r0
// are discarded, decode gets read-after-write hazard flags, and the pipeline
// is asked to freeze when the FIFO head has been blocked too long.
module regfile_wr_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wr_arbiter_if.slave   bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO_C  = {CNT_W{1'b0}};
    localparam logic [WAIT_W-1:0] MAX_WAIT_C  = WAIT_W'(MAX_WAIT);
    localparam logic [ADDR_W-1:0] ZERO_ADDR_C = {ADDR_W{1'b0}};

    // FIFO storage and bookkeeping
    logic [ADDR_W-1:0] fifo_addr_r [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    // Registered write port
    logic              rf_we_r;
    logic [ADDR_W-1:0] rf_waddr_r;
    logic [DATA_W-1:0] rf_wdata_r;

    // Per-cycle decisions
    logic md_ready_s;
    logic push_s;
    logic pop_s;
    logic wb_write_s;
    logic fifo_empty_s;
    logic hit_a_s;
    logic hit_b_s;
    logic haz_a_s;
    logic haz_b_s;
    logic stall_req_s;

    // Accept/grant decisions; md_ready uses the count before any same-cycle pop
    always_comb begin
        md_ready_s   = 1'b0;
        fifo_empty_s = (count_r == CNT_ZERO_C);
        if (rst) begin
            md_ready_s = 1'b0;
        end else begin
            md_ready_s = (count_r < DEPTH_C);
        end
        push_s      = bus.md_valid && md_ready_s && (bus.md_addr != ZERO_ADDR_C);
        wb_write_s  = bus.wb_valid && (bus.wb_addr != ZERO_ADDR_C);
        // A writeback to r0 still owns the slot, so the FIFO only drains when wb_valid is low
        pop_s       = !rst && !bus.wb_valid && !fifo_empty_s;
        stall_req_s = !rst && (wait_cnt_r == MAX_WAIT_C);
    end

    // Search occupied FIFO entries for pending writes to either decode source
    always_comb begin
        logic [PTR_W-1:0] off_v;
        logic             occ_v;
        hit_a_s = 1'b0;
        hit_b_s = 1'b0;
        off_v   = {PTR_W{1'b0}};
        occ_v   = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off_v   = PTR_W'(i) - rd_ptr_r;
            occ_v   = ({1'b0, off_v} < count_r);
            hit_a_s = hit_a_s | (occ_v & (fifo_addr_r[i] == bus.rs_addr));
            hit_b_s = hit_b_s | (occ_v & (fifo_addr_r[i] == bus.rt_addr));
        end
    end

    // Hazard flags include the write currently on the port, since the bank's
    // registered read still returns the old value on that cycle
    always_comb begin
        haz_a_s = !rst && (bus.rs_addr != ZERO_ADDR_C) &&
                  (hit_a_s || (rf_we_r && (rf_waddr_r == bus.rs_addr)));
        haz_b_s = !rst && (bus.rt_addr != ZERO_ADDR_C) &&
                  (hit_b_s || (rf_we_r && (rf_waddr_r == bus.rt_addr)));
    end

    // FIFO payload storage; contents are don't-care until counted as occupied
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.md_addr;
            fifo_data_r[wr_ptr_r] <= bus.md_data;
        end
    end

    // FIFO pointers, occupancy, starvation counter and the registered write port
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= CNT_ZERO_C;
            wait_cnt_r <= {WAIT_W{1'b0}};
            rf_we_r    <= 1'b0;
            rf_waddr_r <= ZERO_ADDR_C;
            rf_wdata_r <= {DATA_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase

            if (wb_write_s) begin
                rf_we_r    <= 1'b1;
                rf_waddr_r <= bus.wb_addr;
                rf_wdata_r <= bus.wb_data;
            end else if (pop_s) begin
                rf_we_r    <= 1'b1;
                rf_waddr_r <= fifo_addr_r[rd_ptr_r];
                rf_wdata_r <= fifo_data_r[rd_ptr_r];
            end else begin
                rf_we_r    <= 1'b0;
            end

            if (pop_s || fifo_empty_s) begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (bus.wb_valid && (wait_cnt_r != MAX_WAIT_C)) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    assign bus.md_ready   = md_ready_s;
    assign bus.haz_a      = haz_a_s;
    assign bus.haz_b      = haz_b_s;
    assign bus.stall_req  = stall_req_s;
    assign bus.fifo_count = count_r;
    assign bus.rf_we      = rf_we_r;
    assign bus.rf_waddr   = rf_waddr_r;
    assign bus.rf_wdata   = rf_wdata_r;
endmodule
